// File: rtl/keypad_scanner_param_pkg.sv
// Shared types and helpers for the parametrised keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    DEBOUNCE = 3'd2,
    HELD     = 3'd3,
    REL_DB   = 3'd4,
    WAIT_CLR = 3'd5
  } state_t;

  // Wide enough for the largest supported keypad; callers slice to ROWS.
  localparam logic [15:0] ROW_IDLE = '1;

  function automatic int code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_scanner_param_if.sv
// Keypad pin and key-event bundle between the scanner and the control logic.
interface keypad_scanner_param_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = keypad_pkg::code_w(ROWS, COLS)
);
  import keypad_pkg::*;

  logic [ROWS-1:0]   row;
  logic [COLS-1:0]   col;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;
  logic              key_release;
  logic              multi_err;
  state_t            state;

  // key_valid, key_release and multi_err are single-cycle strobes with no
  // ready/back-pressure: the consumer must take them in the cycle they are
  // high. key_code is stable from one key_valid until the next.
  modport master (
    input  row,
    output col, key_code, key_valid, key_held, key_release, multi_err, state
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held, key_release, multi_err, state
  );
endinterface

// File: rtl/keypad_scanner_param_row_sync.sv
// Two-flop synchroniser for the asynchronous active-low row inputs; resets to all-1.
module keypad_row_sync #(
  parameter int ROWS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] d,
  output logic [ROWS-1:0] q
);
  logic [ROWS-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scanner_param.sv
// ROWS x COLS keypad scanner with debounce, held/release events and multi-key rejection.
// Optional auto-repeat is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner_param
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DEBOUNCE_CYC = 15,
  parameter int SCAN_DWELL   = 3,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input logic                   clk,
  input logic                   rst_n,
  keypad_scanner_param_if.master bus
);
  localparam int CODE_W  = code_w(ROWS, COLS);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_MAX = (DEBOUNCE_CYC > SCAN_DWELL) ? DEBOUNCE_CYC : SCAN_DWELL;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CW-1:0]    COL_LAST   = CW'(COLS - 1);
  localparam logic [ROWS-1:0]  ROW_ALL    = ROW_IDLE[ROWS-1:0];

  // The sync pipe is two cycles deep, so a column must dwell at least three.
  if (ROWS < 1 || ROWS > 16 || COLS < 1 || COLS > 16 || DEBOUNCE_CYC < 1 ||
      SCAN_DWELL < 3 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scanner_param: parameter out of range");
  end

  logic [ROWS-1:0] rs;

  keypad_row_sync #(.ROWS(ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst_n),
    .d   (bus.row),
    .q   (rs)
  );

  state_t            state;
  logic [COLS-1:0]   col_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q, held_q, release_q, multi_q;
  logic [CNT_W-1:0]  cnt;
  logic [CW-1:0]     c_q;
  logic [RW-1:0]     r_q;
  logic [ROWS-1:0]   pat_q;
  logic [RW-1:0]     row_idx;
  logic              any_low, one_low;

  assign any_low = (rs != ROW_ALL);
  assign one_low = $onehot(~rs);

  always_comb begin
    row_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!rs[i]) row_idx = RW'(i);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);
  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      col_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
      release_q <= 1'b0;
      multi_q   <= 1'b0;
      cnt       <= '0;
      c_q       <= '0;
      r_q       <= '0;
      pat_q     <= '1;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b0;
`endif
    end else begin
      valid_q   <= 1'b0;
      release_q <= 1'b0;
      multi_q   <= 1'b0;
      case (state)
        IDLE: begin
          col_q <= '0;
          cnt   <= '0;
          if (any_low) begin
            state <= SCAN;
            c_q   <= '0;
            col_q <= ~COLS'(1);
          end
        end
        SCAN: begin
          if (cnt != DWELL_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (one_low) begin
              r_q   <= row_idx;
              pat_q <= rs;
              state <= DEBOUNCE;
            end else if (any_low) begin
              multi_q <= 1'b1;
              col_q   <= '0;
              state   <= WAIT_CLR;
            end else if (c_q != COL_LAST) begin
              c_q   <= c_q + 1'b1;
              col_q <= ~(COLS'(1) << (c_q + 1'b1));
            end else begin
              col_q <= '0;
              state <= IDLE;
            end
          end
        end
        DEBOUNCE: begin
          if (rs != pat_q) begin
            col_q <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            code_q  <= CODE_W'(int'(r_q) * COLS + int'(c_q));
            valid_q <= 1'b1;
            held_q  <= 1'b1;
            cnt     <= '0;
            state   <= HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (rs == ROW_ALL) begin
            cnt   <= '0;
            state <= REL_DB;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= '0;
`endif
          end
`ifdef KEYPAD_REPEAT_EN
          // First repeat waits the long delay, later ones the shorter rate.
          else if (rep_cnt == (rep_first ? DELAY_LAST : RATE_LAST)) begin
            valid_q   <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        REL_DB: begin
          if (rs != ROW_ALL) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == DEB_LAST) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            col_q     <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_CLR: begin
          col_q <= '0;
          if (any_low) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          col_q <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.col         = col_q;
  assign bus.key_code    = code_q;
  assign bus.key_valid   = valid_q;
  assign bus.key_held    = held_q;
  assign bus.key_release = release_q;
  assign bus.multi_err   = multi_q;
  assign bus.state       = state;
endmodule

// File: tb/tb_keypad_scanner_param.sv
// Directed bench for keypad_scanner_param with a keypad matrix model and key-code scoreboard.
// Exercises the KEYPAD_REPEAT_EN repeat schedule when that macro is defined.
module tb_keypad_scanner_param;
  import keypad_pkg::*;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DEB    = 15;
  localparam int DWELL  = 3;
  localparam int RD     = 50;
  localparam int RR     = 20;
  localparam int CODE_W = 4;
  // Cycles from a raw pin change until the FSM acts on it (2 sync flops + 1).
  localparam int SEE    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_param_if #(.ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W)) bus ();

  keypad_scanner_param #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYC(DEB), .SCAN_DWELL(DWELL),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  logic [ROWS*COLS-1:0] keys = '0;
  logic [ROWS-1:0]      row_model;
  always_comb begin
    row_model = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !bus.col[c]) row_model[r] = 1'b0;
  end
  assign bus.row = row_model;

  int checks = 0;
  int failures = 0;
  logic [CODE_W-1:0] exp_q[$];
  logic [CODE_W-1:0] last_code = '0;
  logic [CODE_W-1:0] exp_code;
  logic prev_held = 1'b0;

  // Scoreboard: a fresh key_valid pops the expected code, a repeat must keep it.
  always @(negedge clk) begin
    if (rst_n) begin
      prev_held = 1'b0;
    end else begin
      if (bus.key_valid) begin
        checks++;
        if (prev_held) begin
          assert (bus.key_code === last_code) else begin
            failures++;
            $error("FAIL repeat_code got=%0d exp=%0d", bus.key_code, last_code);
          end
        end else begin
          assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_valid got_code=%0d exp=none", bus.key_code);
          end
          if (exp_q.size() != 0) begin
            exp_code = exp_q.pop_front();
            last_code = exp_code;
            checks++;
            assert (bus.key_code === exp_code) else begin
              failures++;
              $error("FAIL key_code got=%0d exp=%0d", bus.key_code, exp_code);
            end
          end
        end
      end
      checks++;
      assert (!(bus.key_valid && bus.key_release)) else begin
        failures++;
        $error("FAIL valid_and_release got=1 exp=0");
      end
      prev_held = bus.key_held;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!bus.key_valid && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(bus.key_valid), 32'd1);
  endtask

  task automatic wait_release(input string tag, output int n);
    int held_low;
    n = 0;
    held_low = 0;
    while (!bus.key_release && n < 300) begin
      tick();
      n++;
      if (!bus.key_release && !bus.key_held) held_low++;
    end
    check({tag, "_rel_timeout"}, 32'(bus.key_release), 32'd1);
    check({tag, "_held_until_rel"}, 32'(held_low), 32'd0);
    check({tag, "_held_cleared"}, 32'(bus.key_held), 32'd0);
  endtask

  int n, cnt_valid, cnt_multi, cnt_rel, cnt_held;
  logic [COLS-1:0] col_seen[$];
  logic [COLS-1:0] col_exp[$];
  logic [COLS-1:0] onehot;
  int rep_seen[$];
  int rep_exp[$];

  initial begin
    // Reset state
    rst_n = 1'b1;
    tick(3);
    rst_n = 1'b0;
    check("rst_col", 32'(bus.col), 32'h0);
    check("rst_code", 32'(bus.key_code), 32'h0);
    check("rst_flags", {28'h0, bus.key_valid, bus.key_held, bus.key_release, bus.multi_err}, 32'h0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    tick(5);

    // Key row1/col2 -> code 6, held 60 cycles from press
    exp_q.push_back(4'd6);
    keys[1*COLS+2] = 1'b1;
    wait_valid("k6", n);
    check("k6_latency", 32'(n), 32'(SEE + DWELL*3 + DEB));
    check("k6_held", 32'(bus.key_held), 32'd1);
    cnt_valid = 0;
    for (int i = 0; i < 60 - n; i++) begin
      tick();
      if (bus.key_valid) cnt_valid++;
    end
    check("k6_single_valid", 32'(cnt_valid), 32'd0);
    check("k6_col_held", 32'(bus.col), 32'b1011);
    check("k6_state_held", 32'(bus.state), 32'(HELD));
    keys = '0;
    wait_release("k6", n);
    check("k6_rel_latency", 32'(n), 32'(SEE + DEB));
    check("k6_code_stable", 32'(bus.key_code), 32'd6);
    tick();
    check("k6_idle", 32'(bus.state), 32'(IDLE));
    check("k6_col_idle", 32'(bus.col), 32'h0);

    // Short bounce on row0/col0: no event
    keys[0] = 1'b1;
    cnt_valid = 0;
    cnt_held = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.key_valid) cnt_valid++;
      if (bus.key_held) cnt_held++;
    end
    keys = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.key_valid) cnt_valid++;
      if (bus.key_held) cnt_held++;
    end
    check("bounce_no_valid", 32'(cnt_valid), 32'd0);
    check("bounce_no_held", 32'(cnt_held), 32'd0);
    check("bounce_idle", 32'(bus.state), 32'(IDLE));

    // Rows 0 and 2 in col1: one multi_err, then WAIT_CLR until rows are clear
    keys[0*COLS+1] = 1'b1;
    keys[2*COLS+1] = 1'b1;
    cnt_multi = 0;
    cnt_valid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.multi_err) cnt_multi++;
      if (bus.key_valid) cnt_valid++;
    end
    check("multi_once", 32'(cnt_multi), 32'd1);
    check("multi_no_valid", 32'(cnt_valid), 32'd0);
    check("multi_wait_clr", 32'(bus.state), 32'(WAIT_CLR));
    check("multi_col_low", 32'(bus.col), 32'h0);
    keys = '0;
    n = 0;
    while (bus.state != IDLE && n < 100) begin
      tick();
      n++;
    end
    check("multi_clr_latency", 32'(n), 32'(SEE - 1 + DEB));

    // Last key row3/col3 -> code 15, scan walks columns 0..3
    exp_q.push_back(4'd15);
    for (int c = 0; c < COLS; c++) begin
      onehot = '0;
      onehot[c] = 1'b1;
      for (int d = 0; d < DWELL; d++) col_exp.push_back(~onehot);
    end
    keys[3*COLS+3] = 1'b1;
    n = 0;
    while (!bus.key_valid && n < 300) begin
      tick();
      n++;
      if (bus.state == SCAN) col_seen.push_back(bus.col);
    end
    check("k15_valid", 32'(bus.key_valid), 32'd1);
    check("k15_latency", 32'(n), 32'(SEE + DWELL*4 + DEB));
    check("scan_len", 32'(col_seen.size()), 32'(col_exp.size()));
    for (int i = 0; i < col_exp.size() && i < col_seen.size(); i++)
      check($sformatf("scan_col%0d", i), 32'(col_seen[i]), 32'(col_exp[i]));
    tick(10);
    keys = '0;
    wait_release("k15", n);
    check("k15_rel_latency", 32'(n), 32'(SEE + DEB));
    tick(3);

    // Reset while HELD: immediate clear, no release pulse
    exp_q.push_back(4'd5);
    keys[1*COLS+1] = 1'b1;
    wait_valid("k5", n);
    tick(5);
    rst_n = 1'b1;
    keys = '0;
    tick();
    rst_n = 1'b0;
    check("hrst_col", 32'(bus.col), 32'h0);
    check("hrst_held", 32'(bus.key_held), 32'd0);
    check("hrst_release", 32'(bus.key_release), 32'd0);
    check("hrst_state", 32'(bus.state), 32'(IDLE));
    cnt_rel = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.key_release) cnt_rel++;
    end
    check("hrst_no_release", 32'(cnt_rel), 32'd0);
    exp_q.push_back(4'd10);
    keys[2*COLS+2] = 1'b1;
    wait_valid("k10", n);
    check("k10_latency", 32'(n), 32'(SEE + DWELL*3 + DEB));
    tick(5);
    keys = '0;
    wait_release("k10", n);
    tick(3);

    // Long hold of row1/col3 (code 7): repeats only with the repeat feature
    exp_q.push_back(4'd7);
    keys[1*COLS+3] = 1'b1;
    wait_valid("k7", n);
    for (int i = 1; i <= 135; i++) begin
      tick();
      if (bus.key_valid) rep_seen.push_back(i);
    end
`ifdef KEYPAD_REPEAT_EN
    for (int t = RD; t <= 135; t += RR) rep_exp.push_back(t);
`endif
    check("rep_count", 32'(rep_seen.size()), 32'(rep_exp.size()));
    for (int i = 0; i < rep_exp.size() && i < rep_seen.size(); i++)
      check($sformatf("rep_at%0d", i), 32'(rep_seen[i]), 32'(rep_exp[i]));
    check("k7_code", 32'(bus.key_code), 32'd7);
    keys = '0;
    wait_release("k7", n);
    tick(5);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
